pixel_line_packer: RTL and testbench

Downstream stage of the ADC controller. Takes 14-bit samples from the ADC data register/valid pulse, subtracts a programmable dark offset with floor clamping, and packs pixel pairs into 32-bit words tagged with an end-of-line flag. Words are buffered in a synchronous FIFO and drained through a valid/ready stream toward the readout/host interface. The block also keeps line-count and overflow status for the register bank.

---
 rtl/pixel_line_packer.sv | 193 +++++++++++++++++++
 tb/tb_pixel_line_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_line_packer
// Description : Dark-offset correction with floor clamp, packing of pixel
//               pairs into 32-bit words with an end-of-line tag, show-ahead
//               word FIFO with a valid/ready drain, line and error status.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_line_packer #(
    parameter int DATA_W     = 14,   // sample width, must be below 16
    parameter int LINE_LEN   = 2048, // pixels per line, even and >= 2
    parameter int FIFO_DEPTH = 512   // words, power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          line_start,
    input  logic                          sample_valid,
    input  logic [DATA_W-1:0]             sample_data,
    input  logic [DATA_W-1:0]             offset,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   line_count,
    output logic                          overflow,
    output logic                          line_err,
    input  logic                          status_clr
);

    localparam int C_AW  = $clog2(FIFO_DEPTH);
    localparam int C_IW  = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 1;
    localparam int C_PAD = 16 - DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;

    localparam logic [C_IW-1:0] C_LAST_IDX = C_IW'(LINE_LEN - 1);

    // ---------------- stage 1: offset subtract with floor clamp -------------
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_corr;
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_corr;

    // A borrow out of the widened subtract means the sample is below offset.
    assign w_diff = {1'b0, sample_data} - {1'b0, offset};
    assign w_corr = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];

    // Register the corrected sample and its valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_corr  <= '0;
        end else begin
            r_s1_valid <= sample_valid;
            if (sample_valid) begin
                r_s1_corr <= w_corr;
            end
        end
    end

    // ---------------- stage 2: pair packing FSM ------------------------------
    logic [1:0]        r_state, w_state_nx;
    logic [C_IW-1:0]   r_idx, w_idx_nx;
    logic [DATA_W-1:0] r_hold, w_hold_nx;
    logic              w_push, w_push_last, w_err_set;
    logic [31:0]       w_push_data;

    // The stage-2 pixel is resolved first; a same-cycle line_start then
    // restarts on top of the post-pixel state (flushing a half-filled pair).
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_hold_nx   = r_hold;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_data = '0;
        w_err_set   = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                S_IDLE: w_err_set = 1'b1;
                S_EVEN: begin
                    w_hold_nx  = r_s1_corr;
                    w_idx_nx   = r_idx + 1'b1;
                    w_state_nx = S_ODD;
                end
                S_ODD: begin
                    w_push      = 1'b1;
                    w_push_data = {{C_PAD{1'b0}}, r_s1_corr, {C_PAD{1'b0}}, r_hold};
                    w_push_last = (r_idx == C_LAST_IDX);
                    if (r_idx == C_LAST_IDX) begin
                        w_idx_nx   = '0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_idx_nx   = r_idx + 1'b1;
                        w_state_nx = S_EVEN;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        if (line_start) begin
            if (w_state_nx == S_ODD) begin
                w_push      = 1'b1;
                w_push_data = {16'h0, {C_PAD{1'b0}}, w_hold_nx};
                w_push_last = 1'b1;
                w_err_set   = 1'b1;
            end else if ((w_state_nx == S_EVEN) && (w_idx_nx != '0)) begin
                w_err_set   = 1'b1;
            end
            w_state_nx = S_EVEN;
            w_idx_nx   = '0;
        end
    end

    // Packing state, pixel index and held even pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_hold  <= w_hold_nx;
        end
    end

    // ---------------- word FIFO ----------------------------------------------
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [C_AW:0] r_wptr, r_rptr;
    logic          w_empty, w_full, w_wr, w_rd;
    logic [32:0]   w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                     (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
    // A full FIFO rejects the push even if a pop happens in the same cycle.
    assign w_wr    = w_push && !w_full;
    assign w_rd    = !w_empty && out_ready;
    assign w_head  = r_mem[r_rptr[C_AW-1:0]];

    // Storage array; content is qualified by the pointers so needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[C_AW-1:0]] <= {w_push_last, w_push_data};
        end
    end

    // Read and write pointers, one bit wider than the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 32'h0 : w_head[31:0];
    assign out_last   = w_empty ? 1'b0  : w_head[32];
    assign fifo_level = r_wptr - r_rptr;

    // ---------------- status -------------------------------------------------
    logic [15:0] r_line_count;
    logic        r_overflow, r_line_err;

    // Line counter counts every end-of-line word, dropped or not; sticky flags
    // give a same-cycle set priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_count <= '0;
            r_overflow   <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            if (w_push && w_push_last) r_line_count <= r_line_count + 16'd1;
            if (w_push && w_full)      r_overflow   <= 1'b1;
            else if (status_clr)       r_overflow   <= 1'b0;
            if (w_err_set)             r_line_err   <= 1'b1;
            else if (status_clr)       r_line_err   <= 1'b0;
        end
    end

    assign line_count = r_line_count;
    assign overflow   = r_overflow;
    assign line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_line_packer
// Description : Directed bench for pixel_line_packer (LINE_LEN=4, 4-word FIFO)
//               with a randomised-backpressure scoreboard phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_line_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [13:0] sample_data = '0;
    logic [13:0] offset = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  fifo_level;
    logic [15:0] line_count;
    logic        overflow;
    logic        line_err;
    logic        status_clr = 1'b0;

    logic        dir_ready = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        mon_en = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    logic [32:0] q[$];

    int n_cmp = 0;
    int n_err = 0;

    assign out_ready = mon_en ? rnd_ready : dir_ready;

    always #5 clk = ~clk;

    pixel_line_packer #(.DATA_W(14), .LINE_LEN(4), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .sample_valid(sample_valid), .sample_data(sample_data), .offset(offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .fifo_level(fifo_level), .line_count(line_count),
        .overflow(overflow), .line_err(line_err), .status_clr(status_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] s);
        sample_valid = 1'b1;
        sample_data  = s;
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic lstart();
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic sclr();
        status_clr = 1'b1;
        cyc();
        status_clr = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] d, input logic l);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, out_last, l);
        dir_ready = 1'b1;
        cyc();
        dir_ready = 1'b0;
    endtask

    // Random ready generation plus scoreboard and stall-stability checks.
    always @(negedge clk) begin
        if (mon_en) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            rnd_ready = r;
            if (out_valid) begin
                if (stalled) check("stable", out_data, held);
                if (r) begin
                    if (q.size() == 0) check("unexpected_word", 1'b1, 1'b0);
                    else check("sb_word", {out_last, out_data}, q.pop_front());
                end
                stalled = !r;
                held    = out_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [13:0] e, o, ce, co;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        // reset state
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_level", fifo_level, 0);
        check("rst_lc", line_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_lerr", line_err, 0);

        // basic pack
        offset = 14'd10;
        lstart();
        send(110); send(210); send(310); send(410);
        cyc();
        check("basic_level", fifo_level, 2);
        check("basic_lc", line_count, 1);
        check("basic_lerr", line_err, 0);
        pop_check("basic_w0", 32'h00C80064, 1'b0);
        pop_check("basic_w1", 32'h0190012C, 1'b1);
        check("empty_valid", out_valid, 0);
        check("empty_data", out_data, 0);

        // clamp and two-clock latency
        offset = 14'h100;
        lstart();
        send(14'h050); send(14'h3FFF);
        check("lat_early", out_valid, 0);
        cyc();
        check("lat_valid", out_valid, 1);
        send(14'h100); send(14'h101);
        cyc();
        pop_check("clamp_w0", 32'h3EFF0000, 1'b0);
        pop_check("clamp_w1", 32'h00010000, 1'b1);
        check("clamp_lc", line_count, 2);

        // truncated line: line_start lands with the third pixel in stage 2
        offset = 14'd0;
        lstart();
        send(7); send(8); send(9);
        lstart();
        send(1); send(2); send(3); send(4);
        cyc();
        check("trunc_lerr", line_err, 1);
        check("trunc_lc", line_count, 4);
        pop_check("trunc_w0", 32'h00080007, 1'b0);
        pop_check("trunc_flush", 32'h00000009, 1'b1);
        pop_check("trunc_n0", 32'h00020001, 1'b0);
        pop_check("trunc_n1", 32'h00040003, 1'b1);
        check("trunc_ovf", overflow, 0);
        sclr();
        check("lerr_clr", line_err, 0);

        // restart from EVEN mid-line: no flush
        lstart();
        send(1); send(2);
        cyc();
        lstart();
        check("even_lerr", line_err, 1);
        send(3); send(4); send(5); send(6);
        cyc();
        check("even_level", fifo_level, 3);
        check("even_lc", line_count, 5);
        pop_check("even_w0", 32'h00020001, 1'b0);
        pop_check("even_w1", 32'h00040003, 1'b0);
        pop_check("even_w2", 32'h00060005, 1'b1);
        sclr();

        // overflow: five words into four entries
        lstart(); send(1); send(2); send(3); send(4);
        lstart(); send(5); send(6); send(7); send(8);
        lstart(); send(9); send(10);
        cyc();
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_lc", line_count, 7);
        pop_check("ovf_w0", 32'h00020001, 1'b0);
        pop_check("ovf_w1", 32'h00040003, 1'b1);
        pop_check("ovf_w2", 32'h00060005, 1'b0);
        pop_check("ovf_w3", 32'h00080007, 1'b1);
        check("ovf_drained", out_valid, 0);
        sclr();
        check("ovf_clr", overflow, 0);

        // simultaneous push and pop keeps the level
        lstart(); send(1); send(2); send(3); send(4);
        cyc();
        check("sim_pre", fifo_level, 2);
        lstart();
        send(5);
        sample_valid = 1'b1; sample_data = 14'd6;
        cyc();
        sample_valid = 1'b0;
        dir_ready = 1'b1;
        cyc();
        dir_ready = 1'b0;
        check("sim_level", fifo_level, 2);
        pop_check("sim_w0", 32'h00040003, 1'b1);
        pop_check("sim_w1", 32'h00060005, 1'b0);
        check("sim_lc", line_count, 8);

        // random backpressure over 64 lines
        offset = 14'h200;
        mon_en = 1'b1;
        for (int ln = 0; ln < 64; ln++) begin
            lstart();
            for (int p = 0; p < 2; p++) begin
                e  = 14'($urandom_range(0, 16383));
                o  = 14'($urandom_range(0, 16383));
                ce = (e >= 14'h200) ? e - 14'h200 : 14'h0;
                co = (o >= 14'h200) ? o - 14'h200 : 14'h0;
                send(e); repeat (3) cyc();
                q.push_back({(p == 1), 2'b00, co, 2'b00, ce});
                send(o); repeat (3) cyc();
            end
        end
        for (int i = 0; i < 400 && q.size() != 0; i++) cyc();
        repeat (2) cyc();
        mon_en = 1'b0;
        cyc();
        check("rnd_queue", q.size(), 0);
        check("rnd_level", fifo_level, 0);
        check("rnd_ovf", overflow, 0);
        check("rnd_lc", line_count, 72);

        // reset mid-line with two words queued
        offset = 14'd0;
        lstart(); send(1); send(2); send(3); send(4);
        lstart(); send(5);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_last", out_last, 0);
        check("mrst_level", fifo_level, 0);
        check("mrst_lc", line_count, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_lerr", line_err, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        send(100);
        cyc();
        check("mrst_idle_err", line_err, 1);
        check("mrst_idle_lvl", fifo_level, 0);
        sclr();
        lstart(); send(10); send(20); send(30); send(40);
        cyc();
        check("mrst_new_level", fifo_level, 2);
        check("mrst_new_lc", line_count, 1);
        pop_check("mrst_w0", 32'h0014000A, 1'b0);
        pop_check("mrst_w1", 32'h0028001E, 1'b1);
        check("mrst_new_lerr", line_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
